spi_reg_bridge: RTL and testbench

- SPI slave that converts host (Raspberry Pi) SPI frames into register-file bus cycles.
- Sits directly upstream of the address decoder / register file.
- Drives address, write_en, wr_data and read_en; captures rd_data.
- All SPI pins are synchronised into the single system clock domain and edge-detected; no logic runs on SCK.

---
 rtl/spi_reg_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns 16-bit host frames into register-file
// read/write strobes. Define SPI_TIMEOUT_EN to abort frames whose SCK stalls.
module spi_reg_bridge #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef SPI_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [5:0] address,
    output logic       write_en,
    output logic [7:0] wr_data,
    output logic       read_en,
    input  logic [7:0] rd_data,
    output logic       frame_err
);
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RDLOAD,
        RDATA,
        WDATA,
        DRAIN
    } state_t;

    state_t state, state_d;

    logic [SYNC_N-1:0] sck_sync, cs_sync, mosi_sync;
    logic              sck_q, cs_q;
    logic              sck_s, cs_s, mosi_s;
    logic              sck_rise, sck_fall, cs_rise, cs_fall;
    logic              timeout_hit;

    logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [6:0]       rx_shift, rx_shift_d;
    logic [7:0]       rx_byte;
    logic [7:0]       tx_shift, tx_shift_d;
    logic [5:0]       address_d;
    logic [7:0]       wr_data_d;
    logic             write_en_d, read_en_d, miso_d, oe_d, err_d;

    // Pin synchronisers, reset to idle bus levels, plus one stage for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_N-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_N-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_N-2:0], spi_mosi};
            sck_q     <= sck_s;
            cs_q      <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_N-1];
    assign cs_s     = cs_sync[SYNC_N-1];
    assign mosi_s   = mosi_sync[SYNC_N-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_fall  = ~cs_s & cs_q;
    assign cs_rise  = cs_s & ~cs_q;
    assign rx_byte  = {rx_shift, mosi_s};

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_active;

    // DRAIN is excluded so a host lingering with CS low after a good frame is not flagged
    assign tmo_active  = (state != IDLE) && (state != DRAIN);
    assign timeout_hit = tmo_active && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (!tmo_active || sck_rise || sck_fall || cs_fall) begin
            tmo_cnt <= '0;
        end else if (!timeout_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output values; CS edges override everything else
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        rx_shift_d = rx_shift;
        tx_shift_d = tx_shift;
        address_d  = address;
        wr_data_d  = wr_data;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        miso_d     = spi_miso;
        oe_d       = spi_miso_oe;
        err_d      = frame_err;

        if (cs_rise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            if (state != IDLE && state != DRAIN) begin
                err_d = 1'b1;
            end
        end else if (cs_fall) begin
            state_d    = CMD;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_shift_d = '0;
            oe_d       = 1'b1;
            miso_d     = 1'b0;
            err_d      = 1'b0;
        end else if (timeout_hit) begin
            state_d = DRAIN;
            miso_d  = 1'b0;
            err_d   = 1'b1;
        end else begin
            unique case (state)
                IDLE: miso_d = 1'b0;
                CMD: begin
                    if (sck_rise) begin
                        bit_cnt_d  = bit_cnt + CNT_W'(1);
                        rx_shift_d = rx_byte[6:0];
                        if (bit_cnt == CNT_W'(7)) begin
                            address_d = rx_byte[5:0];
                            if (rx_byte[6]) begin
                                err_d   = 1'b1;
                                state_d = DRAIN;
                            end else if (rx_byte[7]) begin
                                read_en_d = 1'b1;
                                state_d   = RDLOAD;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                // rd_data is valid the clock after the read_en cycle
                RDLOAD: begin
                    if (!read_en) begin
                        tx_shift_d = {rd_data[6:0], 1'b0};
                        miso_d     = rd_data[7];
                        state_d    = RDATA;
                    end
                end
                // The fall that closes byte0 must not shift: bit7 is already on MISO
                RDATA: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(15)) begin
                            state_d = DRAIN;
                            miso_d  = 1'b0;
                        end
                    end else if (sck_fall && bit_cnt != CNT_W'(8)) begin
                        miso_d     = tx_shift[7];
                        tx_shift_d = {tx_shift[6:0], 1'b0};
                    end
                end
                WDATA: begin
                    if (sck_rise) begin
                        bit_cnt_d  = bit_cnt + CNT_W'(1);
                        rx_shift_d = rx_byte[6:0];
                        if (bit_cnt == CNT_W'(15)) begin
                            wr_data_d  = rx_byte;
                            write_en_d = 1'b1;
                            state_d    = DRAIN;
                        end
                    end
                end
                DRAIN:   miso_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            address     <= '0;
            wr_data     <= '0;
            write_en    <= 1'b0;
            read_en     <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            rx_shift    <= rx_shift_d;
            tx_shift    <= tx_shift_d;
            address     <= address_d;
            wr_data     <= wr_data_d;
            write_en    <= write_en_d;
            read_en     <= read_en_d;
            spi_miso    <= miso_d;
            spi_miso_oe <= oe_d;
            frame_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: a host-side SPI driver, a register-file read
// model and a frame-level reference model of the expected strobes, MISO bits and errors.
module tb_spi_reg_bridge;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [5:0] address;
    logic       write_en;
    logic [7:0] wr_data;
    logic       read_en;
    logic [7:0] rd_data = 8'h00;
    logic       frame_err;

    logic [7:0]  mem [64];
    logic [13:0] wr_log [$];
    logic [5:0]  rd_log [$];
    int          both_cnt = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    typedef struct {
        int          n_wr;
        int          n_rd;
        logic [13:0] wr;
        logic        err;
        logic [15:0] miso;
    } exp_t;

    always #5 clock = ~clock;

    spi_reg_bridge #(.SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .address    (address),
        .write_en   (write_en),
        .wr_data    (wr_data),
        .read_en    (read_en),
        .rd_data    (rd_data),
        .frame_err  (frame_err)
    );

    // Register file read port: data valid the clock after read_en
    always @(posedge clock) begin
        if (read_en) rd_data <= mem[address];
    end

    // Strobe monitor
    always @(negedge clock) begin
        if (write_en) wr_log.push_back({address, wr_data});
        if (read_en) rd_log.push_back(address);
        if (write_en && read_en) both_cnt++;
    end

    // Frame-level expectation: what a host frame of nbits should produce
    function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1, input int nbits);
        exp_t e;
        logic cmd_ok;
        cmd_ok = (nbits >= 8) && !b0[6];
        e.n_wr = (cmd_ok && !b0[7] && nbits == 16) ? 1 : 0;
        e.n_rd = (cmd_ok && b0[7]) ? 1 : 0;
        e.wr   = {b0[5:0], b1};
        e.err  = (nbits < 16) || b0[6];
        e.miso = (e.n_rd == 1) ? {8'h00, mem[b0[5:0]]} : 16'h0000;
        for (int i = nbits; i < 16; i++) e.miso[15-i] = 1'b0;
        return e;
    endfunction

    // Host master, mode 0: MOSI changes with SCK low, MISO sampled just before each rise
    task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                             input int half, input int gap, input int stall_at, input bit rst_mid,
                             output logic [15:0] miso_bits, output logic oe_mid);
        logic [15:0] tx;
        tx        = {b0, b1};
        miso_bits = '0;
        oe_mid    = 1'b0;
        @(negedge clock);
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[15-i];
            if (i == stall_at) repeat (4200) @(negedge clock);
            repeat (half) @(negedge clock);
            if (i == 4) oe_mid = spi_miso_oe;
            miso_bits[15-i] = spi_miso;
            spi_sck = 1'b1;
            repeat (half) @(negedge clock);
            spi_sck = 1'b0;
        end
        if (rst_mid) begin
            reset_n = 1'b0;
            #1;
        end else begin
            repeat (half) @(negedge clock);
            spi_cs_n = 1'b1;
            spi_mosi = 1'b0;
            repeat (gap) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({address, wr_data, write_en, read_en, spi_miso, spi_miso_oe, frame_err} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0h wd=%0h we=%0b re=%0b miso=%0b oe=%0b err=%0b expected all 0",
                     address, wr_data, write_en, read_en, spi_miso, spi_miso_oe, frame_err);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_write_read();
        exp_t        e;
        logic [15:0] mb;
        logic        oe;
        logic [7:0]  b0, b1;
        int          h;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                b0 = 8'h04; b1 = 8'hA5; h = 8;
            end else if (k == 1) begin
                b0 = 8'h8E; b1 = 8'h00; h = 8;
            end else begin
                b0 = {1'($urandom_range(0, 1)), 1'b0, 6'($urandom_range(0, 63))};
                b1 = 8'($urandom);
                h  = $urandom_range(4, 10);
            end
            e = model(b0, b1, 16);
            wr_log.delete();
            rd_log.delete();
            spi_frame(b0, b1, 16, h, 8, -1, 1'b0, mb, oe);
            n_tests++;
            if (wr_log.size() != e.n_wr || rd_log.size() != e.n_rd) begin
                n_fail++;
                $display("FAIL wr_rd_strobes[%0d]: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                         k, wr_log.size(), rd_log.size(), e.n_wr, e.n_rd);
            end else if (e.n_wr == 1) begin
                n_tests++;
                if (wr_log[0] !== e.wr) begin
                    n_fail++;
                    $display("FAIL wr_payload[%0d]: got %0h expected %0h", k, wr_log[0], e.wr);
                end
            end else begin
                n_tests++;
                if (rd_log[0] !== b0[5:0]) begin
                    n_fail++;
                    $display("FAIL rd_addr[%0d]: got %0h expected %0h", k, rd_log[0], b0[5:0]);
                end
            end
            n_tests++;
            if (mb !== e.miso) begin
                n_fail++;
                $display("FAIL wr_rd_miso[%0d]: got %0h expected %0h", k, mb, e.miso);
            end
            n_tests++;
            if ({frame_err, address} !== {e.err, b0[5:0]}) begin
                n_fail++;
                $display("FAIL wr_rd_err_addr[%0d]: got err=%0b addr=%0h expected err=%0b addr=%0h",
                         k, frame_err, address, e.err, b0[5:0]);
            end
            n_tests++;
            if ({oe, spi_miso_oe} !== 2'b10) begin
                n_fail++;
                $display("FAIL wr_rd_oe[%0d]: got mid=%0b after=%0b expected 1 0", k, oe, spi_miso_oe);
            end
        end
    endtask

    task automatic test_frame_errors();
        exp_t        e;
        logic [15:0] mb;
        logic        oe;
        logic [7:0]  t0 [7];
        logic [7:0]  t1 [7];
        int          tn [7];
        t0 = '{8'h01, 8'h3A, 8'h8E, 8'h44, 8'hC7, 8'h15, 8'h20};
        t1 = '{8'hFF, 8'h11, 8'h00, 8'h12, 8'h00, 8'h66, 8'h00};
        tn = '{12, 16, 12, 16, 16, 16, 5};
        for (int k = 0; k < 7; k++) begin
            e = model(t0[k], t1[k], tn[k]);
            wr_log.delete();
            rd_log.delete();
            spi_frame(t0[k], t1[k], tn[k], 8, 8, -1, 1'b0, mb, oe);
            n_tests++;
            if (wr_log.size() != e.n_wr || rd_log.size() != e.n_rd) begin
                n_fail++;
                $display("FAIL err_strobes[%0d]: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                         k, wr_log.size(), rd_log.size(), e.n_wr, e.n_rd);
            end else if (e.n_wr == 1) begin
                n_tests++;
                if (wr_log[0] !== e.wr) begin
                    n_fail++;
                    $display("FAIL err_payload[%0d]: got %0h expected %0h", k, wr_log[0], e.wr);
                end
            end
            n_tests++;
            if (frame_err !== e.err) begin
                n_fail++;
                $display("FAIL err_flag[%0d]: got %0b expected %0b", k, frame_err, e.err);
            end
            n_tests++;
            if (mb !== e.miso) begin
                n_fail++;
                $display("FAIL err_miso[%0d]: got %0h expected %0h", k, mb, e.miso);
            end
            if (tn[k] >= 8) begin
                n_tests++;
                if (address !== t0[k][5:0]) begin
                    n_fail++;
                    $display("FAIL err_addr[%0d]: got %0h expected %0h", k, address, t0[k][5:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mb;
        logic        oe;
        wr_log.delete();
        rd_log.delete();
        spi_frame(8'h20, 8'h80, 16, 8, 1, -1, 1'b0, mb, oe);
        spi_frame(8'h23, 8'h7F, 16, 8, 8, -1, 1'b0, mb, oe);
        n_tests++;
        if (wr_log.size() != 2 || rd_log.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got wr=%0d rd=%0d expected wr=2 rd=0", wr_log.size(), rd_log.size());
        end else begin
            n_tests++;
            if (wr_log[0] !== {6'h20, 8'h80} || wr_log[1] !== {6'h23, 8'h7F}) begin
                n_fail++;
                $display("FAIL b2b_payload: got %0h %0h expected 2080 237f", wr_log[0], wr_log[1]);
            end
        end
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err: got %0b expected 0", frame_err);
        end
        n_tests++;
        if (both_cnt != 0) begin
            n_fail++;
            $display("FAIL strobe_overlap: got %0d cycles with both strobes expected 0", both_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] mb;
        logic        oe;
        wr_log.delete();
        rd_log.delete();
        spi_frame(8'h8E, 8'h00, 12, 8, 8, -1, 1'b1, mb, oe);
        n_tests++;
        if ({address, wr_data, write_en, read_en, spi_miso, spi_miso_oe, frame_err} !== 19'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got addr=%0h wd=%0h we=%0b re=%0b miso=%0b oe=%0b err=%0b expected all 0",
                     address, wr_data, write_en, read_en, spi_miso, spi_miso_oe, frame_err);
        end
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        n_tests++;
        if (wr_log.size() != 0 || rd_log.size() != 1) begin
            n_fail++;
            $display("FAIL midreset_strobes: got wr=%0d rd=%0d expected wr=0 rd=1", wr_log.size(), rd_log.size());
        end
        n_tests++;
        if ({spi_miso_oe, frame_err, address} !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_idle: got oe=%0b err=%0b addr=%0h expected 0 0 0", spi_miso_oe, frame_err, address);
        end
    endtask

`ifdef SPI_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] mb;
        logic        oe;
        wr_log.delete();
        rd_log.delete();
        spi_frame(8'h05, 8'h5A, 16, 8, 8, 11, 1'b0, mb, oe);
        n_tests++;
        if (wr_log.size() != 0 || rd_log.size() != 0 || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_abort: got wr=%0d rd=%0d err=%0b expected 0 0 1", wr_log.size(), rd_log.size(), frame_err);
        end
        spi_frame(8'h06, 8'h77, 16, 8, 8, -1, 1'b0, mb, oe);
        n_tests++;
        if (wr_log.size() != 1 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recover: got wr=%0d err=%0b expected 1 0", wr_log.size(), frame_err);
        end else begin
            n_tests++;
            if (wr_log[0] !== {6'h06, 8'h77}) begin
                n_fail++;
                $display("FAIL timeout_payload: got %0h expected 677", wr_log[0]);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[14] = 8'h3C;
        test_reset();
        test_write_read();
        test_frame_errors();
        test_back_to_back();
        test_reset_mid_read();
`ifdef SPI_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
